// File: rtl/pwidth_trig_pkg.sv
// pwidth_trig_pkg: function-select encodings and FSM state type shared by
// the pulse-width trigger block.
package pwidth_trig_pkg;

   typedef enum logic [1:0] {
      FS_GT  = 2'b00,
      FS_LT  = 2'b01,
      FS_IN  = 2'b10,
      FS_OUT = 2'b11
   } func_sel_e;

   typedef enum logic [1:0] {
      IDLE,
      ARMED,
      MEASURE,
      EVAL
   } state_e;

endpackage

// File: rtl/pwidth_trig_if.sv
// pwidth_trig_if: control, threshold and result signals of pwidth_trig.
// The master drives controls and thresholds; the slave (the trigger) returns results.
interface pwidth_trig_if #(
   parameter int unsigned CNT_W = 32
);
   logic             en;
   logic             trigin;
   logic             pol;
   logic [1:0]       func_sel;
   logic [CNT_W-1:0] cmp_low;
   logic [CNT_W-1:0] cmp_high;
   logic             pul_trig;
   logic             pul_trig_status;
   logic [CNT_W-1:0] width;
   logic             width_vld;
   logic             width_sat;

   modport master (
      output en, trigin, pol, func_sel, cmp_low, cmp_high,
      input  pul_trig, pul_trig_status, width, width_vld, width_sat
   );

   modport slave (
      input  en, trigin, pol, func_sel, cmp_low, cmp_high,
      output pul_trig, pul_trig_status, width, width_vld, width_sat
   );
endinterface

// File: rtl/pwidth_sync.sv
// pwidth_sync: trigin synchroniser, polarity select and rise/fall detect.
module pwidth_sync #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic cnt_clk,
   input  logic cnt_clr,
   input  logic trigin,
   input  logic pol,
   output logic s,
   output logic s_rise,
   output logic s_fall,
   output logic s_valid
);
   logic [SYNC_STAGES-1:0] sync_q;
   logic [SYNC_STAGES-1:0] fill_q;
   logic                   edge_q;

   // fill_q marks when the chain holds trigin sampled after reset release,
   // so a level left over from reset is never mistaken for an idle level.
   always_ff @(posedge cnt_clk) begin
      if (cnt_clr) begin
         sync_q <= '0;
         fill_q <= '0;
         edge_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], trigin};
         fill_q <= {fill_q[SYNC_STAGES-2:0], 1'b1};
         edge_q <= s;
      end
   end

   always_comb begin
      s       = sync_q[SYNC_STAGES-1] ^ pol;
      s_rise  = s & ~edge_q;
      s_fall  = ~s & edge_q;
      s_valid = fill_q[SYNC_STAGES-1];
   end

endmodule

// File: rtl/pwidth_trig.sv
// pwidth_trig: measures qualified trigin pulse widths and strobes pul_trig on a match.
// Define PWIDTH_TRIG_EARLY_EN to fire GT/OUT matches as soon as the count passes cmp_high.
module pwidth_trig #(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned SYNC_STAGES = 2
) (
   input logic          cnt_clk,
   input logic          cnt_clr,
   pwidth_trig_if.slave bus
);
   import pwidth_trig_pkg::*;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   logic             s, s_rise, s_fall, s_valid;
   state_e           state_q, state_d;
   func_sel_e        fs_q, fs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W-1:0] lo_q, lo_d, hi_q, hi_d;
   logic [CNT_W-1:0] width_q, width_d;
   logic             sat_q, sat_d, wsat_q, wsat_d;
   logic             status_q, status_d;
   logic             trig_q, trig_d, vld_q, vld_d;
   logic             lt_hit, gt_hit, hit;

   pwidth_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .cnt_clk (cnt_clk),
      .cnt_clr (cnt_clr),
      .trigin  (bus.trigin),
      .pol     (bus.pol),
      .s       (s),
      .s_rise  (s_rise),
      .s_fall  (s_fall),
      .s_valid (s_valid)
   );

   always_comb begin
      lt_hit = cnt_q < lo_q;
      gt_hit = cnt_q > hi_q;
      hit    = 1'b0;
      unique case (fs_q)
         FS_GT:   hit = gt_hit;
         FS_LT:   hit = lt_hit;
         FS_IN:   hit = (cnt_q > lo_q) && (cnt_q < hi_q);
         default: hit = lt_hit | gt_hit;
      endcase
   end

`ifdef PWIDTH_TRIG_EARLY_EN
   logic             early_q, early_d, early_hit;
   logic [CNT_W:0]   hi_inc;

   // Extended by one bit so cmp_high = all-ones can never match.
   always_comb begin
      hi_inc    = {1'b0, hi_q} + {{CNT_W{1'b0}}, 1'b1};
      early_hit = ((fs_q == FS_GT) || (fs_q == FS_OUT)) && ({1'b0, cnt_q} == hi_inc);
   end
`endif

   always_comb begin
      state_d  = state_q;
      fs_d     = fs_q;
      cnt_d    = cnt_q;
      lo_d     = lo_q;
      hi_d     = hi_q;
      sat_d    = sat_q;
      width_d  = width_q;
      wsat_d   = wsat_q;
      status_d = status_q;
      trig_d   = 1'b0;
      vld_d    = 1'b0;
`ifdef PWIDTH_TRIG_EARLY_EN
      early_d  = early_q;
`endif
      if (!bus.en) begin
         state_d = IDLE;
         cnt_d   = '0;
         sat_d   = 1'b0;
`ifdef PWIDTH_TRIG_EARLY_EN
         early_d = 1'b0;
`endif
      end else begin
         unique case (state_q)
            IDLE: begin
               if (s_valid && !s) state_d = ARMED;
            end
            ARMED: begin
               if (s_rise) begin
                  state_d = MEASURE;
                  cnt_d   = CNT_ONE;
                  sat_d   = &CNT_ONE;
                  fs_d    = func_sel_e'(bus.func_sel);
                  lo_d    = bus.cmp_low;
                  hi_d    = bus.cmp_high;
`ifdef PWIDTH_TRIG_EARLY_EN
                  early_d = 1'b0;
`endif
               end
            end
            MEASURE: begin
               if (s_fall) begin
                  state_d = EVAL;
               end else if (cnt_q != '1) begin
                  cnt_d = cnt_q + CNT_ONE;
                  if (cnt_d == '1) sat_d = 1'b1;
               end
`ifdef PWIDTH_TRIG_EARLY_EN
               if (early_hit && !early_q) begin
                  trig_d   = 1'b1;
                  status_d = 1'b1;
                  early_d  = 1'b1;
               end
`endif
            end
            EVAL: begin
               state_d  = ARMED;
               width_d  = cnt_q;
               wsat_d   = sat_q;
               vld_d    = 1'b1;
               status_d = hit;
`ifdef PWIDTH_TRIG_EARLY_EN
               trig_d   = hit && !early_q;
`else
               trig_d   = hit;
`endif
               cnt_d    = '0;
               sat_d    = 1'b0;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge cnt_clk) begin
      if (cnt_clr) begin
         state_q  <= IDLE;
         fs_q     <= FS_GT;
         cnt_q    <= '0;
         lo_q     <= '0;
         hi_q     <= '0;
         sat_q    <= 1'b0;
         width_q  <= '0;
         wsat_q   <= 1'b0;
         status_q <= 1'b0;
         trig_q   <= 1'b0;
         vld_q    <= 1'b0;
`ifdef PWIDTH_TRIG_EARLY_EN
         early_q  <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         fs_q     <= fs_d;
         cnt_q    <= cnt_d;
         lo_q     <= lo_d;
         hi_q     <= hi_d;
         sat_q    <= sat_d;
         width_q  <= width_d;
         wsat_q   <= wsat_d;
         status_q <= status_d;
         trig_q   <= trig_d;
         vld_q    <= vld_d;
`ifdef PWIDTH_TRIG_EARLY_EN
         early_q  <= early_d;
`endif
      end
   end

   assign bus.pul_trig        = trig_q;
   assign bus.pul_trig_status = status_q;
   assign bus.width           = width_q;
   assign bus.width_vld       = vld_q;
   assign bus.width_sat       = wsat_q;

endmodule

// File: tb/tb_pwidth_trig.sv
// tb_pwidth_trig: drives two pwidth_trig builds (16-bit/3-stage and 4-bit/2-stage)
// with directed and random pulses and checks them against a width/compare model.
module tb_pwidth_trig;
   localparam int unsigned AW = 16;
   localparam int unsigned AS = 3;
   localparam int unsigned BW = 4;
   localparam int unsigned BS = 2;
   localparam longint AMAX = (64'd1 << AW) - 1;
   localparam longint BMAX = (64'd1 << BW) - 1;

   logic   cnt_clk = 1'b0;
   logic   cnt_clr;
   longint cyc = 0;
   int     checks = 0;
   int     failures = 0;
   logic   pol_cur = 1'b0;

   always #5 cnt_clk = ~cnt_clk;
   always @(posedge cnt_clk) cyc <= cyc + 1;

   pwidth_trig_if #(.CNT_W(AW)) ia ();
   pwidth_trig_if #(.CNT_W(BW)) ib ();

   pwidth_trig #(.CNT_W(AW), .SYNC_STAGES(AS)) u_a (
      .cnt_clk (cnt_clk),
      .cnt_clr (cnt_clr),
      .bus     (ia)
   );

   pwidth_trig #(.CNT_W(BW), .SYNC_STAGES(BS)) u_b (
      .cnt_clk (cnt_clk),
      .cnt_clr (cnt_clr),
      .bus     (ib)
   );

   int          a_tn = 0, a_vn = 0, b_tn = 0, b_vn = 0;
   longint      a_tc = 0, a_vc = 0, b_tc = 0, b_vc = 0;
   logic [63:0] a_w = '0, b_w = '0;
   logic        a_s = 1'b0, b_s = 1'b0;

   always @(posedge cnt_clk) begin
      #1;
      if (ia.pul_trig === 1'b1) begin a_tn++; a_tc = cyc; end
      if (ia.width_vld === 1'b1) begin a_vn++; a_vc = cyc; a_w = 64'(ia.width); a_s = ia.width_sat; end
      if (ib.pul_trig === 1'b1) begin b_tn++; b_tc = cyc; end
      if (ib.width_vld === 1'b1) begin b_vn++; b_vc = cyc; b_w = 64'(ib.width); b_s = ib.width_sat; end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic model_hit(input int fs, input longint w, input longint lo, input longint hi);
      case (fs)
         0:       return w > hi;
         1:       return w < lo;
         2:       return (w > lo) && (w < hi);
         default: return (w < lo) || (w > hi);
      endcase
   endfunction

   task automatic drive_trig(input logic v);
      ia.trigin = v;
      ib.trigin = v;
   endtask

   task automatic drive_en(input logic v);
      ia.en = v;
      ib.en = v;
   endtask

   task automatic set_pol(input logic p);
      @(negedge cnt_clk);
      drive_en(1'b0);
      ia.pol = p;
      ib.pol = p;
      drive_trig(p);
      pol_cur = p;
      repeat (6) @(negedge cnt_clk);
      drive_en(1'b1);
      repeat (6) @(negedge cnt_clk);
   endtask

   task automatic verify(input string tag, input int S, input longint maxv, input int fs,
                         input longint lo, input longint hi, input int len,
                         input longint L, input longint E, input int tn, input longint tc,
                         input int vn, input longint vc, input logic [63:0] w_obs,
                         input logic sat_obs, input logic st_obs);
      longint w;
      logic   hit;
      longint exp_tc;
      w      = (len > maxv) ? maxv : longint'(len);
      hit    = model_hit(fs, w, lo, hi);
      exp_tc = E + S + 1;
`ifdef PWIDTH_TRIG_EARLY_EN
      if (((fs == 0) || (fs == 3)) && (w > hi)) exp_tc = L + S + hi + 1;
`endif
      chk({tag, " vld_count"}, 64'(vn), 64'd1);
      chk({tag, " vld_latency"}, 64'(vc - E + 1), 64'(S + 2));
      chk({tag, " width"}, w_obs, 64'(w));
      chk({tag, " width_sat"}, 64'(sat_obs), 64'(len >= maxv));
      chk({tag, " status"}, 64'(st_obs), 64'(hit));
      chk({tag, " trig_count"}, 64'(tn), 64'(hit));
      if (hit) chk({tag, " trig_latency"}, 64'(tc - L), 64'(exp_tc - L));
   endtask

   task automatic do_pulse(input string tag, input int fs, input longint lo, input longint hi, input int len);
      longint L, E;
      int     a_tn0, a_vn0, b_tn0, b_vn0;
      @(negedge cnt_clk);
      ia.func_sel = 2'(fs);
      ib.func_sel = 2'(fs);
      ia.cmp_low  = AW'(lo);
      ia.cmp_high = AW'(hi);
      ib.cmp_low  = BW'(lo);
      ib.cmp_high = BW'(hi);
      a_tn0 = a_tn; a_vn0 = a_vn; b_tn0 = b_tn; b_vn0 = b_vn;
      drive_trig(~pol_cur);
      L = cyc + 1;
      repeat (len) @(negedge cnt_clk);
      drive_trig(pol_cur);
      E = cyc + 1;
      repeat (12) @(negedge cnt_clk);
      verify({tag, ".A"}, AS, AMAX, fs, lo & AMAX, hi & AMAX, len, L, E, a_tn - a_tn0, a_tc,
             a_vn - a_vn0, a_vc, a_w, a_s, ia.pul_trig_status);
      verify({tag, ".B"}, BS, BMAX, fs, lo & BMAX, hi & BMAX, len, L, E, b_tn - b_tn0, b_tc,
             b_vn - b_vn0, b_vc, b_w, b_s, ib.pul_trig_status);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, " A.pul_trig"}, 64'(ia.pul_trig), 64'd0);
      chk({tag, " A.status"}, 64'(ia.pul_trig_status), 64'd0);
      chk({tag, " A.width"}, 64'(ia.width), 64'd0);
      chk({tag, " A.width_vld"}, 64'(ia.width_vld), 64'd0);
      chk({tag, " A.width_sat"}, 64'(ia.width_sat), 64'd0);
      chk({tag, " B.status"}, 64'(ib.pul_trig_status), 64'd0);
      chk({tag, " B.width"}, 64'(ib.width), 64'd0);
      chk({tag, " B.width_sat"}, 64'(ib.width_sat), 64'd0);
   endtask

   initial begin
      int a_tn0, a_vn0, b_tn0, b_vn0;
      cnt_clr = 1'b1;
      drive_en(1'b1);
      drive_trig(1'b0);
      ia.pol = 1'b0; ib.pol = 1'b0;
      ia.func_sel = 2'd0; ib.func_sel = 2'd0;
      ia.cmp_low = '0; ia.cmp_high = '0;
      ib.cmp_low = '0; ib.cmp_high = '0;
      repeat (4) @(negedge cnt_clk);
      chk_reset_outputs("reset");
      cnt_clr = 1'b0;
      repeat (8) @(negedge cnt_clk);

      // GT at and just above the bound
      do_pulse("gt11", 0, 0, 10, 11);
      do_pulse("gt10", 0, 0, 10, 10);
      // IN window, both bounds excluded
      do_pulse("in5", 2, 5, 8, 5);
      do_pulse("in6", 2, 5, 8, 6);
      do_pulse("in8", 2, 5, 8, 8);
      do_pulse("lt4", 1, 5, 8, 4);
      do_pulse("in_empty", 2, 8, 5, 6);
      do_pulse("gt_sat", 0, 0, 14, 40);
      do_pulse("gt30", 0, 0, 10, 30);
      do_pulse("w1", 3, 2, 20, 1);

      // Low pulses with OUT
      set_pol(1'b1);
      do_pulse("pol1_out", 3, 3, 20, 2);
      do_pulse("pol1_out_mid", 3, 3, 20, 9);
      set_pol(1'b0);

      // Reset asserted mid-pulse; trigin still high at release
      @(negedge cnt_clk);
      ia.func_sel = 2'd0; ib.func_sel = 2'd0;
      ia.cmp_high = AW'(30); ib.cmp_high = BW'(14);
      a_tn0 = a_tn; a_vn0 = a_vn; b_tn0 = b_tn; b_vn0 = b_vn;
      drive_trig(1'b1);
      repeat (3) @(negedge cnt_clk);
      cnt_clr = 1'b1;
      repeat (3) @(negedge cnt_clk);
      chk_reset_outputs("midreset");
      cnt_clr = 1'b0;
      repeat (14) @(negedge cnt_clk);
      drive_trig(1'b0);
      repeat (12) @(negedge cnt_clk);
      chk("rst_discard A.vld", 64'(a_vn - a_vn0), 64'd0);
      chk("rst_discard B.vld", 64'(b_vn - b_vn0), 64'd0);
      chk("rst_discard A.trig", 64'(a_tn - a_tn0), 64'd0);
      do_pulse("after_rst", 0, 0, 10, 15);

      // en dropped mid-pulse: nothing reported, previous results held
      @(negedge cnt_clk);
      ia.cmp_high = AW'(30); ib.cmp_high = BW'(15);
      a_tn0 = a_tn; a_vn0 = a_vn; b_tn0 = b_tn; b_vn0 = b_vn;
      drive_trig(1'b1);
      repeat (5) @(negedge cnt_clk);
      drive_en(1'b0);
      repeat (3) @(negedge cnt_clk);
      drive_en(1'b1);
      repeat (12) @(negedge cnt_clk);
      drive_trig(1'b0);
      repeat (12) @(negedge cnt_clk);
      chk("en_abort A.vld", 64'(a_vn - a_vn0), 64'd0);
      chk("en_abort B.vld", 64'(b_vn - b_vn0), 64'd0);
      chk("en_abort A.trig", 64'(a_tn - a_tn0), 64'd0);
      chk("en_abort B.trig", 64'(b_tn - b_tn0), 64'd0);
      chk("en_abort A.width_hold", 64'(ia.width), 64'd15);
      chk("en_abort B.width_hold", 64'(ib.width), 64'd15);
      chk("en_abort A.status_hold", 64'(ia.pul_trig_status), 64'd1);
      do_pulse("after_en", 1, 9, 20, 7);

      for (int i = 0; i < 30; i++) begin
         if ($urandom_range(0, 5) == 0) set_pol(~pol_cur);
         do_pulse("rand", int'($urandom_range(0, 3)), longint'($urandom_range(0, 30)),
                  longint'($urandom_range(0, 30)), int'($urandom_range(1, 40)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/pwidth_trig.md
PWIDTH_TRIG -- requirements
Module: pwidth_trig

Interface
REQ-001 Parameter CNT_W, default 32: width of pulse counter, thresholds and measured width.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: synchroniser flops on trigin.
REQ-003 cnt_clk  in  1  sole clock; all state on rising edge.
REQ-004 cnt_clr  in  1  reset, synchronous, active-high.
REQ-005 en  in  1  1 = measure/trigger enabled; 0 = forced to IDLE, counter cleared.
REQ-006 trigin  in  1  asynchronous comparator output to be qualified.
REQ-007 pol  in  1  0 = measure high pulses, 1 = measure low pulses.
REQ-008 func_sel  in  2  00 GT (width>cmp_high), 01 LT (width<cmp_low), 10 IN (cmp_low<width<cmp_high), 11 OUT (width<cmp_low or width>cmp_high).
REQ-009 cmp_low  in  CNT_W  lower bound, unsigned, in cnt_clk cycles.
REQ-010 cmp_high  in  CNT_W  upper bound, unsigned, in cnt_clk cycles.
REQ-011 pul_trig  out  1  one-cycle trigger strobe on qualifying pulse.
REQ-012 pul_trig_status  out  1  result of last evaluation, held until next evaluation.
REQ-013 width  out  CNT_W  last measured width; width_vld  out  1  one-cycle strobe when width updates; width_sat  out  1  last measurement saturated.

Function
REQ-014 trigin SHALL pass SYNC_STAGES flops then one edge-detect flop; level s = synced trigin XOR pol.
REQ-015 FSM states SHALL be IDLE, ARMED, MEASURE, EVAL.
REQ-016 IDLE: wait for s==0 (no partial pulse measured) -> ARMED.
REQ-017 ARMED: on s rising edge -> MEASURE, counter loaded with 1; func_sel, cmp_low, cmp_high latched at this edge and used for the whole pulse.
REQ-018 MEASURE: counter +1 per cycle while s==1, saturating at all-ones (no wrap), sat flag set on reaching all-ones; on s falling edge -> EVAL.
REQ-019 EVAL (exactly one cycle): width<=counter, width_sat<=sat, width_vld=1, pul_trig_status<=compare result, pul_trig=result; -> ARMED.
REQ-020 Comparisons SHALL be strict unsigned; width equal to either bound never qualifies as LT/GT/IN; IN never fires when cmp_low>=cmp_high; OUT fires for every width when cmp_low>cmp_high is irrelevant (OUT = LT or GT, evaluated independently).
REQ-021 Latency: pul_trig SHALL assert SYNC_STAGES+2 cnt_clk cycles after the first edge sampling trigin at its trailing level.
REQ-022 Measured width SHALL equal number of cnt_clk cycles s was high, exactly (±0 for synchronous stimulus).
REQ-023 en deasserted in any state SHALL go to IDLE next cycle, clear counter, suppress pul_trig/width_vld; pul_trig_status and width hold.
REQ-024 Pulse starting while in IDLE or EVAL SHALL NOT be measured; next full pulse is.

Reset
REQ-025 cnt_clr=1 SHALL force: synchroniser and edge flops 0, FSM IDLE, counter 0, pul_trig 0, pul_trig_status 0, width 0, width_vld 0, width_sat 0; cnt_clr mid-pulse discards that pulse.

Configuration
REQ-026 Macro PWIDTH_TRIG_EARLY_EN defined: in GT and OUT modes, pul_trig SHALL fire the cycle counter reaches cmp_high+1 in MEASURE (once per pulse), pul_trig_status set then; EVAL still updates width/width_vld but SHALL NOT re-fire pul_trig.
REQ-027 Macro undefined: all triggering only in EVAL per REQ-019; no early-fire logic present.

Structure
REQ-028 Package pwidth_trig_pkg SHALL hold func_sel encodings (FS_GT, FS_LT, FS_IN, FS_OUT) and FSM state enum.
REQ-029 Sub-module pwidth_sync SHALL implement synchroniser, polarity XOR and rise/fall edge detect; FSM, counter, compare in pwidth_trig.

Verification
REQ-030 GT, cmp_high=10, pol=0, high pulse 11 cycles -> pul_trig one cycle, status 1, width=11; pulse 10 cycles -> no pul_trig, status 0, width=10.
REQ-031 IN, low=5 high=8: widths 5,6,8 -> pul_trig only for 6; LT low=5 width 4 -> fires.
REQ-032 pol=1, OUT, low=3 high=20, low pulse 2 cycles -> fires, width=2; trigin high pulses ignored.
REQ-033 CNT_W=4, GT high=14, pulse 40 cycles -> width=15, width_sat=1, pul_trig fires once.
REQ-034 Reset pulled 3 cycles into a 20-cycle pulse, and trigin high at reset release -> no width_vld until a complete later pulse; en toggled low mid-pulse -> same.
REQ-035 With PWIDTH_TRIG_EARLY_EN, GT high=10, 30-cycle pulse -> pul_trig when count=11 (before trailing edge), single strobe, width_vld at end with width=30.
